ic_fetch_unit: RTL
==================

// Module: ic_fetch_unit
// PURPOSE
//   Instruction fetch stage directly downstream of icache_top (CPU side). Generates
//   sequential 16-byte line addresses, performs the cpu_addr/cpu_read_valid/ack
//   handshake with the icache, buffers returned 128-bit lines and issues 32-bit
//   instructions with PC to the decoder via valid/ready. Branch redirects flush the stage.
// PARAMETERS
//   AW        33     byte address width (matches icache aw)
//   DW        128    icache line width
//   IW        32     instruction width; DW/IW = 4 words per line
//   DEPTH     2      line buffer entries (power of 2, >=2)
//   RESET_PC  33'h0  fetch start address after reset
// PORTS
//   clk              in   1   clock
//   rst              in   1   reset, asynchronous, active-high
//   cpu_addr_o       out  AW  line request address to icache, bits [3:0] always 0
//   cpu_read_valid_o out  1   1-cycle request pulse to icache
//   ic_data_i        in   DW  line data from icache
//   ic_addr_i        in   AW  line address returned with data
//   cpu_read_ack_i   in   1   icache data valid, 1-cycle pulse
//   redirect_valid_i in   1   branch/exception redirect strobe
//   redirect_pc_i    in   AW  redirect target; bits [1:0] ignored
//   inst_o           out  IW  instruction to decoder
//   inst_pc_o        out  AW  byte PC of inst_o
//   inst_valid_o     out  1   inst_o/inst_pc_o valid
//   inst_ready_i     in   1   decoder accepts
//   fetch_err_o      out  1   sticky address-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//   - Clock clk; reset rst asynchronous, active-high. Reset: all outputs 0, buffer empty,
//     fetch_pc=RESET_PC, drop=0, state IDLE. Ack arriving during reset ignored.
//   - FSM: IDLE -> REQ (first cycle after reset release, or redirect);
//     REQ: cpu_read_valid_o=1 one cycle, cpu_addr_o={fetch_pc[AW-1:4],4'h0} -> WAIT;
//     WAIT: on ack -> REQ if space else FULL; FULL -> REQ when an entry pops.
//     Request issued only if occupancy + outstanding < DEPTH; max one outstanding.
//   - Ack in WAIT, drop=0: push {line, line addr, start word}; fetch_pc<=line+16,
//     wraps modulo 2^AW (0x1_FFFF_FFF0 -> 0x0). Ack outside WAIT: ignored.
//   - Output comb from buffer head: word sel = rd_word; inst_o=line[32*sel+:32] (word0 =
//     bits[31:0]); inst_pc_o=line_addr+4*sel. valid&ready advances rd_word; consuming
//     word 3 pops entry, next entry starts at its start word (0 unless first after redirect).
//   - Latency: ack at cycle T -> inst_valid_o at T+1. Redirect at T -> request at T+1.
//   - Simultaneous push and pop allowed in one cycle at full occupancy.
//   - Redirect (highest priority): flush buffer, inst_valid_o=0 next cycle, decoder
//     handshake that cycle ignored, fetch_pc<=redirect_pc_i aligned to line, start word
//     =redirect_pc_i[3:2], go REQ. If request outstanding (WAIT, or REQ this cycle) and
//     no ack this cycle, set drop. Ack coincident with redirect discarded, drop not set.
//   - drop=1: next ack discarded, drop cleared, no push, fetch_pc unchanged.
//   - Back-to-back redirects: last one wins; at most one drop pending.
// CONFIGURATION
//   IC_FETCH_ADDR_CHECK_EN defined: on accepted ack, ic_addr_i[AW-1:4] compared to
//     requested line; mismatch -> line discarded, fetch_err_o set (sticky until rst),
//     same line re-requested next cycle.
//   Undefined: ic_addr_i unused, every accepted ack pushed, fetch_err_o tied 0.
// TESTING
//   1 Release rst -> cycle 1 req addr 0x0; ack data 128'h4_0000_0003_0000_0002_0000_0001
//     (words 4,3,2,1 high->low), ready=1 -> inst 1,2,3,4 at pc 0,4,8,C; next req 0x10.
//   2 inst_ready_i=0, acks each request -> exactly 2 lines buffered, no further
//     cpu_read_valid_o; raise ready -> pop after 4 words, new req issued.
//   3 Redirect 0x1_0000_0008 while WAIT -> in-flight ack dropped, next req 0x1_0000_0000,
//     first inst pc 0x1_0000_0008 (word 2), then 0x1_0000_000C, next req 0x1_0000_0010.
//   4 Redirect 0x40 same cycle as ack -> ack data never appears; req 0x40 next cycle.
//   5 Redirect 0x1_FFFF_FFF0 -> after that line, req addr 0x0, inst pc wraps to 0x0.
//   6 Macro defined, ack with ic_addr_i=0x20 for req 0x10 -> no inst, fetch_err_o=1,
//     req 0x10 reissued; macro undefined -> line accepted, fetch_err_o=0.

Source files
------------

// File: rtl/ic_fetch_unit.sv
// Fetch stage: line requests to icache, 2-line buffer, 32b insts to decoder; ack->inst 1 cycle, requests stall while buffer full.
// Define IC_FETCH_ADDR_CHECK_EN to compare the returned line address and flag mismatches on fetch_err_o (sticky).
module ic_fetch_unit #(
  parameter int AW       = 33,
  parameter int DW       = 128,
  parameter int IW       = 32,
  parameter int DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] cpu_addr_o,
  output logic          cpu_read_valid_o,
  input  logic [DW-1:0] ic_data_i,
  input  logic [AW-1:0] ic_addr_i,
  input  logic          cpu_read_ack_i,
  input  logic          redirect_valid_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [IW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_valid_o,
  input  logic          inst_ready_i,
  output logic          fetch_err_o
);

  localparam int LB = $clog2(DW/8);
  localparam int SW = $clog2(DW/IW);
  localparam int BB = $clog2(IW/8);
  localparam int LW = AW - LB;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [LW-1:0] r_fetch_line;
  logic [SW-1:0] r_start_word;
  logic [SW-1:0] r_rd_word;
  logic          r_drop;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;

  logic [DW-1:0] r_line  [DEPTH];
  logic [LW-1:0] r_laddr [DEPTH];
  logic [SW-1:0] r_sw    [DEPTH];

  logic          w_req;
  logic          w_vld;
  logic          w_ack_wait;
  logic          w_addr_ok;
  logic          w_push;
  logic          w_fire;
  logic          w_pop;
  logic          w_outstanding;
  logic [PW:0]   w_cnt_nxt;
  logic [PW-1:0] w_rp_nxt;

  assign w_req         = (r_state == S_REQ) && (r_cnt < CNT_MAX);
  assign w_vld         = (r_cnt != '0);
  assign w_ack_wait    = cpu_read_ack_i && (r_state == S_WAIT) && !r_drop && !redirect_valid_i;
  assign w_push        = w_ack_wait && w_addr_ok;
  assign w_fire        = w_vld && inst_ready_i && !redirect_valid_i;
  assign w_pop         = w_fire && (r_rd_word == '1);
  assign w_outstanding = (r_state == S_WAIT) || w_req;
  assign w_cnt_nxt     = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_rp_nxt      = r_rp + PW'(1);

`ifdef IC_FETCH_ADDR_CHECK_EN
  logic r_fetch_err;
  logic w_unused_bits;

  assign w_addr_ok     = (ic_addr_i[AW-1:LB] == r_fetch_line);
  assign fetch_err_o   = r_fetch_err;
  assign w_unused_bits = ^{ic_addr_i[LB-1:0], redirect_pc_i[BB-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_err <= 1'b0;
    end else if (w_ack_wait && !w_addr_ok) begin
      r_fetch_err <= 1'b1;
    end
  end
`else
  logic w_unused_bits;

  assign w_addr_ok     = 1'b1;
  assign fetch_err_o   = 1'b0;
  assign w_unused_bits = ^{ic_addr_i, redirect_pc_i[BB-1:0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid_i) begin
      w_state_nxt = S_REQ;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ:  w_state_nxt = w_req ? S_WAIT : S_FULL;
        S_WAIT: begin
          // A mismatched line is re-requested; otherwise keep requesting while space remains.
          if (w_ack_wait) begin
            if (!w_addr_ok || (w_cnt_nxt < CNT_MAX)) w_state_nxt = S_REQ;
            else                                     w_state_nxt = S_FULL;
          end
        end
        S_FULL: if (w_pop) w_state_nxt = S_REQ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fetch_line <= RESET_PC[AW-1:LB];
      r_start_word <= RESET_PC[LB-1:BB];
      r_rd_word    <= '0;
      r_drop       <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid_i) begin
        r_fetch_line <= redirect_pc_i[AW-1:LB];
        r_start_word <= redirect_pc_i[LB-1:BB];
        r_rd_word    <= '0;
        r_drop       <= w_outstanding && !cpu_read_ack_i;
        r_wp         <= '0;
        r_rp         <= '0;
        r_cnt        <= '0;
      end else begin
        if (cpu_read_ack_i && r_drop) r_drop <= 1'b0;
        if (w_push) begin
          r_fetch_line <= r_fetch_line + LW'(1);
          r_start_word <= '0;
          r_wp         <= r_wp + PW'(1);
        end
        if (w_pop) r_rp <= w_rp_nxt;
        r_cnt <= w_cnt_nxt;
        // With one entry left, the next head (if any) is the line being pushed now.
        if (w_pop)                           r_rd_word <= (r_cnt > CNT_ONE) ? r_sw[w_rp_nxt] : r_start_word;
        else if (w_fire)                     r_rd_word <= r_rd_word + SW'(1);
        else if (w_push && (r_cnt == '0))    r_rd_word <= r_start_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_line[r_wp]  <= ic_data_i;
      r_laddr[r_wp] <= r_fetch_line;
      r_sw[r_wp]    <= r_start_word;
    end
  end

  assign cpu_read_valid_o = w_req;
  assign cpu_addr_o       = w_req ? {r_fetch_line, {LB{1'b0}}} : '0;
  assign inst_valid_o     = w_vld;
  assign inst_o           = w_vld ? r_line[r_rp][IW*r_rd_word +: IW] : '0;
  assign inst_pc_o        = w_vld ? {r_laddr[r_rp], r_rd_word, {BB{1'b0}}} : '0;

endmodule
